// File: rtl/ov7670_stream_gen_if.sv
// OV7670-style camera stream bus: byte-wide video output plus
// the pixel request/return path used by the external pattern source.
interface ov7670_stream_gen_if;
    logic        pclock;
    logic        href;
    logic        vsync_cam;
    logic [7:0]  data;
    logic        pix_req;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [11:0] pix_in;
    logic        frame_done;

    modport master (
        output pclock, href, vsync_cam, data,
        output pix_req, pix_x, pix_y, frame_done,
        input  pix_in
    );

    modport slave (
        input  pclock, href, vsync_cam, data,
        input  pix_req, pix_x, pix_y, frame_done,
        output pix_in
    );
endinterface

// File: rtl/ov7670_stream_gen.sv
// Emulated OV7670 camera: RGB444 frames on a byte bus with Href/Vsync
// timing, built-in test patterns or externally supplied pixels.
module ov7670_stream_gen #(
    parameter int H_ACTIVE = 176,
    parameter int V_ACTIVE = 144,
    parameter int H_BLANK  = 48,
    parameter int VS_LINES = 3,
    parameter int V_BP     = 2,
    parameter int V_FP     = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    ov7670_stream_gen_if.master cam
);
    localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
    localparam int HW    = $clog2(LINE);
    localparam int VMAX  = V_ACTIVE + VS_LINES + V_BP + V_FP;
    localparam int LW    = $clog2(VMAX + 1);
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(LINE - 1);
    localparam logic [HW-1:0] H_ACT2  = HW'(2 * H_ACTIVE);
    localparam logic [HW-1:0] H_LASTB = HW'(2 * H_ACTIVE - 1);
    localparam logic [LW-1:0] VS_LAST = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] BP_LAST = LW'(V_BP - 1);
    localparam logic [LW-1:0] VA_LAST = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] FP_LAST = LW'(V_FP - 1);
    localparam logic [7:0]    Y_LAST  = 8'(V_ACTIVE - 1);
    localparam logic [7:0]    BAR_W8  = 8'(BAR_W);

    typedef enum logic [2:0] {
        IDLE, VSYNC, VBACK, ACTIVE, VFRONT
    } state_t;

    state_t        state_q, state_n;
    logic [HW-1:0] hcnt_q, hcnt_n;
    logic [LW-1:0] lcnt_q, lcnt_n;
    logic          pclk_q;
    logic [1:0]    mode_q;
    logic [7:0]    pix_x_q, pix_y_q;
    logic [11:0]   pix_q;
    logic          done_q;

    logic          line_end, load_mode, frame_end;
    logic          nxt_act, nxt_first, nxt_second, nxt_blank0;
    logic [7:0]    bar;
    logic [11:0]   bar_rgb, colour;

    // Pclock high means the coming edge is an update edge.
    wire upd = pclk_q;

    // Frame sequencing: line/slot counters and state transitions.
    always_comb begin
        state_n   = state_q;
        hcnt_n    = hcnt_q;
        lcnt_n    = lcnt_q;
        load_mode = 1'b0;
        frame_end = 1'b0;
        line_end  = (hcnt_q == H_LAST);
        if (state_q == IDLE) begin
            if (enable) begin
                state_n   = VSYNC;
                hcnt_n    = '0;
                lcnt_n    = '0;
                load_mode = 1'b1;
            end
        end else begin
            hcnt_n = line_end ? '0 : hcnt_q + 1'b1;
            if (line_end) begin
                lcnt_n = lcnt_q + 1'b1;
                case (state_q)
                    VSYNC:
                        if (lcnt_q == VS_LAST) begin
                            state_n = VBACK;
                            lcnt_n  = '0;
                        end
                    VBACK:
                        if (lcnt_q == BP_LAST) begin
                            state_n = ACTIVE;
                            lcnt_n  = '0;
                        end
                    ACTIVE:
                        if (lcnt_q == VA_LAST) begin
                            state_n = VFRONT;
                            lcnt_n  = '0;
                        end
                    VFRONT:
                        if (lcnt_q == FP_LAST) begin
                            lcnt_n    = '0;
                            frame_end = 1'b1;
                            load_mode = enable;
                            state_n   = enable ? VSYNC : IDLE;
                        end
                    default: ;
                endcase
            end
        end
    end

    // Classify the slot that the next update edge will enter.
    always_comb begin
        nxt_act    = (state_n == ACTIVE);
        nxt_first  = nxt_act && (hcnt_n < H_ACT2) && !hcnt_n[0];
        nxt_second = nxt_act && (hcnt_n < H_ACT2) && hcnt_n[0];
        nxt_blank0 = nxt_act && (hcnt_n == H_ACT2);
    end

    // Pattern colour for the pixel at (pix_x, pix_y).
    always_comb begin
        bar = pix_x_q / BAR_W8;
        if (bar > 8'd7) begin
            bar = 8'd7;
        end
        case (bar[2:0])
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
        case (mode_q)
            2'd0:    colour = bar_rgb;
            2'd1:    colour = {pix_x_q[7:4], pix_y_q[7:4], pix_x_q[3:0]};
            2'd2:    colour = (pix_x_q[4] ^ pix_y_q[4]) ? 12'hFFF : 12'h000;
            default: colour = cam.pix_in;
        endcase
    end

    // State, timing and pixel registers; everything but Pclock and
    // Frame_done moves only on update edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            pclk_q  <= 1'b0;
            mode_q  <= 2'd0;
            pix_x_q <= 8'd0;
            pix_y_q <= 8'd0;
            pix_q   <= 12'd0;
            done_q  <= 1'b0;
        end else begin
            pclk_q <= ~pclk_q;
            done_q <= upd && frame_end;
            if (upd) begin
                state_q <= state_n;
                hcnt_q  <= hcnt_n;
                lcnt_q  <= lcnt_n;
                if (load_mode) begin
                    mode_q <= mode;
                end
                if (nxt_first) begin
                    pix_q <= colour;
                end
                if (!nxt_act) begin
                    pix_x_q <= 8'd0;
                    pix_y_q <= 8'd0;
                end else if (nxt_second && hcnt_n != H_LASTB) begin
                    pix_x_q <= pix_x_q + 8'd1;
                end else if (nxt_blank0) begin
                    pix_x_q <= 8'd0;
                    pix_y_q <= (pix_y_q == Y_LAST) ? 8'd0 : pix_y_q + 8'd1;
                end
            end
        end
    end

    assign cam.pclock     = pclk_q;
    assign cam.href       = (state_q == ACTIVE) && (hcnt_q < H_ACT2);
    assign cam.vsync_cam  = (state_q == VSYNC);
    assign cam.data       = !cam.href ? 8'h00 :
                            hcnt_q[0] ? pix_q[7:0] : {4'b0000, pix_q[11:8]};
    assign cam.pix_req    = upd && nxt_first && (mode_q == 2'd3);
    assign cam.pix_x      = pix_x_q;
    assign cam.pix_y      = pix_y_q;
    assign cam.frame_done = done_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen on a reduced frame geometry:
// 34x6 active, 8 blank Pclocks, 2/1/1 sync/back/front lines.
module tb_ov7670_stream_gen;
    localparam int HA = 34;
    localparam int VA = 6;
    localparam int HB = 8;
    localparam int VS = 2;
    localparam int BP = 1;
    localparam int FP = 1;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode   = 2'd0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_vs, n_href, n_rise, n_fd, n_req, first_rise;
    logic href_d;

    ov7670_stream_gen_if cam();

    ov7670_stream_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VS_LINES(VS), .V_BP(BP), .V_FP(FP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .mode  (mode),
        .cam   (cam)
    );

    // 10 ns system clock.
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        n_vs   += int'(cam.vsync_cam);
        n_href += int'(cam.href);
        n_fd   += int'(cam.frame_done);
        n_req  += int'(cam.pix_req);
        if (cam.href && !href_d) begin
            n_rise++;
            if (first_rise < 0) first_rise = cyc;
        end
        href_d = cam.href;
    endtask

    task automatic go_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_href"},  cam.href, 0);
        check({tag, "_vsync"}, cam.vsync_cam, 0);
        check({tag, "_data"},  cam.data, 0);
        check({tag, "_req"},   cam.pix_req, 0);
        check({tag, "_x"},     cam.pix_x, 0);
        check({tag, "_y"},     cam.pix_y, 0);
        check({tag, "_done"},  cam.frame_done, 0);
    endtask

    initial begin
        cam.pix_in = 12'h000;
        href_d = 1'b0;
        repeat (3) tick();
        check("rst_pclk", cam.pclock, 0);
        check_quiet("rst");

        reset = 1'b0;
        enable = 1'b1;
        cyc = 0;
        n_vs = 0; n_href = 0; n_rise = 0;
        n_fd = 0; n_req = 0; first_rise = -1;

        go_to(1);
        check("pclk_first", cam.pclock, 1);
        check("vs_pre", cam.vsync_cam, 0);
        go_to(2);
        check("pclk_upd", cam.pclock, 0);
        check("vs_start", cam.vsync_cam, 1);
        go_to(100);
        mode = 2'd2;
        go_to(305);
        check("vs_last", cam.vsync_cam, 1);
        go_to(306);
        check("vs_end", cam.vsync_cam, 0);
        go_to(457);
        check("href_pre", cam.href, 0);
        go_to(458);
        check("href_rise", cam.href, 1);
        check("p0_b0", cam.data, 8'h0F);
        check("p0_x", cam.pix_x, 0);
        check("p0_y", cam.pix_y, 0);
        go_to(460);
        check("p0_b1", cam.data, 8'hFF);
        check("p1_x", cam.pix_x, 1);
        go_to(474);
        check("p4_b0", cam.data, 8'h0F);
        check("p4_x", cam.pix_x, 4);
        go_to(476);
        check("p4_b1", cam.data, 8'hF0);
        go_to(554);
        check("p24_b0", cam.data, 8'h00);
        go_to(556);
        check("p24_b1", cam.data, 8'h0F);
        go_to(590);
        check("p33_href", cam.href, 1);
        check("p33_b0", cam.data, 8'h00);
        check("p33_x", cam.pix_x, 33);
        go_to(592);
        check("p33_b1", cam.data, 8'h00);
        check("p33_x2", cam.pix_x, 33);
        go_to(594);
        check("blank_href", cam.href, 0);
        check("blank_data", cam.data, 0);
        check("blank_x", cam.pix_x, 0);
        check("blank_y", cam.pix_y, 1);

        go_to(1521);
        check("n_vsync", n_vs, VS * 2 * (2 * HA + HB));
        check("n_href", n_href, VA * 4 * HA);
        check("n_rise", n_rise, VA);
        check("first_rise", first_rise, 458);
        check("n_done_pre", n_fd, 0);
        check("n_req_m0", n_req, 0);
        check("done_pre", cam.frame_done, 0);
        go_to(1522);
        check("done_f1", cam.frame_done, 1);
        check("vs_f2", cam.vsync_cam, 1);
        go_to(1523);
        check("done_clr", cam.frame_done, 0);

        go_to(1978);
        check("m2_href", cam.href, 1);
        check("m2_p0_b0", cam.data, 8'h00);
        go_to(1980);
        check("m2_p0_b1", cam.data, 8'h00);
        go_to(2038);
        check("m2_p15_b0", cam.data, 8'h00);
        go_to(2042);
        check("m2_p16_b0", cam.data, 8'h0F);
        go_to(2044);
        check("m2_p16_b1", cam.data, 8'hFF);
        go_to(2200);
        enable = 1'b0;
        mode = 2'd3;
        go_to(2346);
        check("m2_y2_b0", cam.data, 8'h0F);
        check("m2_y2_y", cam.pix_y, 2);
        go_to(3041);
        check("done_f2_pre", cam.frame_done, 0);
        go_to(3042);
        check("done_f2", cam.frame_done, 1);
        check("idle_vs", cam.vsync_cam, 0);
        go_to(3100);
        check_quiet("idle");
        enable = 1'b1;
        go_to(3101);
        check("reen_pclk", cam.pclock, 1);
        check("reen_vs0", cam.vsync_cam, 0);
        go_to(3102);
        check("reen_vs1", cam.vsync_cam, 1);
        n_req = 0;

        go_to(4032);
        check("req_pre", cam.pix_req, 0);
        go_to(4033);
        check("req_53", cam.pix_req, 1);
        check("req_x", cam.pix_x, 5);
        check("req_y", cam.pix_y, 3);
        cam.pix_in = 12'h53A;
        go_to(4034);
        check("req_post", cam.pix_req, 0);
        check("ext_b0", cam.data, 8'h05);
        cam.pix_in = 12'h000;
        go_to(4036);
        check("ext_b1", cam.data, 8'h3A);
        go_to(4100);
        mode = 2'd1;
        go_to(4622);
        check("n_req_m3", n_req, HA * VA);
        check("done_f3", cam.frame_done, 1);
        check("vs_f4", cam.vsync_cam, 1);

        go_to(5970);
        check("m1_b0", cam.data, 8'h02);
        check("m1_x", cam.pix_x, 33);
        check("m1_y", cam.pix_y, 5);
        go_to(5971);
        reset = 1'b1;
        go_to(5972);
        check("mrst_pclk", cam.pclock, 0);
        check_quiet("mrst");
        reset = 1'b0;
        go_to(5973);
        check("mrst_pclk1", cam.pclock, 1);
        check("mrst_vs0", cam.vsync_cam, 0);
        go_to(5974);
        check("mrst_vs1", cam.vsync_cam, 1);
        go_to(6429);
        check("mrst_href0", cam.href, 0);
        go_to(6430);
        check("mrst_href1", cam.href, 1);
        check("mrst_b0", cam.data, 8'h00);
        check("mrst_x", cam.pix_x, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ov7670_stream_gen.md
OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

Interface
REQ-001 Parameter H_ACTIVE, default 176: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 144: active lines per frame.
REQ-003 Parameter H_BLANK, default 48: Pclock periods per line with Href low.
REQ-004 Parameter VS_LINES, default 3: line periods Vsync_cam stays high.
REQ-005 Parameter V_BP / V_FP, default 2 / 2: blank line periods after Vsync_cam / after the last active line.
REQ-006 Clock  in  1  system clock; every register clocks on its rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 Enable  in  1  frame generation request; sampled only at frame boundaries.
REQ-009 Mode  in  2  pattern select: 0 colour bars, 1 gradient, 2 checkerboard, 3 external.
REQ-010 Pix_in  in  12  external RGB444 pixel {R,G,B}, used in Mode 3.
REQ-011 Pclock  out  1  emulated camera pixel clock, Clock/2.
REQ-012 Href  out  1  line-valid, high during active bytes.
REQ-013 Vsync_cam  out  1  frame sync, active high.
REQ-014 Data  out  8  camera byte bus.
REQ-015 Pix_req  out  1  external pixel strobe.
REQ-016 Pix_x / Pix_y  out  8 / 8  coordinates of the pixel being emitted or requested.
REQ-017 Frame_done  out  1  one-Clock pulse at end of each frame.

Function
REQ-018 Pclock shall toggle every Clock cycle; the "update edge" is the Clock edge on which Pclock goes 1->0; Href, Vsync_cam, Data, Pix_x and Pix_y shall change only on update edges, so they are stable at every Pclock rising edge.
REQ-019 Line period shall be 2*H_ACTIVE + H_BLANK Pclock periods (400 by default): Href high for the first 2*H_ACTIVE, low for the rest.
REQ-020 FSM states: IDLE, VSYNC (VS_LINES lines), VBACK (V_BP lines), ACTIVE (V_ACTIVE lines), VFRONT (V_FP lines); transitions occur only at line-period boundaries on update edges.
REQ-021 IDLE -> VSYNC when Enable=1 at an update edge; VFRONT end -> VSYNC if Enable=1, else IDLE.
REQ-022 Vsync_cam shall be high exactly during VSYNC; Href shall be low in all states except ACTIVE.
REQ-023 Each pixel shall be sent as two bytes: first {4'b0000, R}, second {G, B}; Data shall be 0 whenever Href=0.
REQ-024 Pix_x counts 0..H_ACTIVE-1 and advances after each second byte; Pix_y counts 0..V_ACTIVE-1 and advances at the end of each active line; both hold 0 outside ACTIVE.
REQ-025 Mode 0: 8 bars of H_ACTIVE/8 pixels, left to right FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000; a remainder pixel uses the last bar.
REQ-026 Mode 1: R=Pix_x[7:4], G=Pix_y[7:4], B=Pix_x[3:0].
REQ-027 Mode 2: FFF when Pix_x[4]^Pix_y[4]=1, else 000.
REQ-028 Mode 3: Pix_req shall be high for the single Clock cycle ending at the update edge that emits a pixel's first byte; Pix_in shall be captured on that edge; Pix_x/Pix_y shall already show that pixel during the Pix_req cycle.
REQ-029 Mode shall be latched on entry to VSYNC; changes mid-frame shall have no effect until the next frame.
REQ-030 Enable falling mid-frame shall not truncate the frame; the frame shall finish through VFRONT.
REQ-031 Frame_done shall pulse for one Clock cycle on the update edge that ends VFRONT.
REQ-032 Default frame length shall be 151 lines = 60400 Pclock = 120800 Clock cycles.

Reset
REQ-033 Reset=1 at a Clock edge shall force IDLE, Pclock=0, Href=0, Vsync_cam=0, Data=0, Pix_req=0, Pix_x=Pix_y=0, Frame_done=0, latched Mode=0, and clear all counters, including mid-line or mid-frame.
REQ-034 After reset release, Pclock shall be 1 on the first cycle; the first update edge shall occur on the second cycle.

Verification
REQ-035 Reset, Enable=1, Mode 0, defaults -> Vsync_cam high 1200 Pclock; first Href rise after 5 lines; 144 Href pulses of 352 Pclock each; Frame_done once every 120800 Clock cycles.
REQ-036 Mode 0, line 0 -> bytes 0F,FF (pixel 0), 0F,F0 (pixel 22), 00,00 (pixel 175); Data=00 during blank.
REQ-037 Mode 3, Pix_in driven as {Pix_x[3:0],Pix_y[3:0],4'hA} -> pixel (5,3) emits bytes 05,3A; one Pix_req per pixel, 176*144 per frame.
REQ-038 Enable dropped at active line 50 -> frame completes, Frame_done pulses, outputs stay low in IDLE; re-raise -> VSYNC on the next update edge.
REQ-039 Mode changed 0->2 mid-frame -> current frame stays bars; next frame at (16,0) emits 0F,FF and at (0,0) emits 00,00.
REQ-040 Reset asserted mid-active-line for one cycle -> all outputs at REQ-033 values on the following cycle; the new frame timing restarts from VSYNC.
